// File: rtl/serial_receiver_fifo.sv
// Oversampled serial receiver with optional even parity, feeding a show-ahead
// word FIFO with sticky overrun / framing / parity error flags.
module serial_receiver_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          data_in,
    input  logic                          sample_en,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          character_received,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          framing_err,
    output logic                          parity_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CTR_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CTR_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         ctr, ctr_n;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  sync1, line;
    logic [1:0]            primed;
    logic                  armed;
    logic                  bad;
    logic                  push_pending;
    logic                  start_frame, shift_en, par_fail, frame_fail, push_req;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  push, pop, drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            line  <= 1'b1;
        end else begin
            sync1 <= data_in;
            line  <= sync1;
        end
    end

    // The synchronizer resets to 1, so the line must be seen high once real
    // samples reach it before a falling edge may start a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            primed <= '0;
            armed  <= 1'b0;
        end else begin
            primed <= {primed[0], 1'b1};
            if (primed[1] && line)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ctr   <= '0;
        end else begin
            state <= state_n;
            ctr   <= ctr_n;
        end
    end

    always_comb begin
        state_n     = state;
        ctr_n       = ctr;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        par_fail    = 1'b0;
        frame_fail  = 1'b0;
        push_req    = 1'b0;
        if (sample_en) begin
            case (state)
                IDLE: begin
                    if (!line && armed) begin
                        state_n     = START;
                        ctr_n       = '0;
                        start_frame = 1'b1;
                    end
                end
                START: begin
                    if (ctr == CTR_HALF) begin
                        ctr_n   = '0;
                        state_n = line ? IDLE : DATA;
                    end else begin
                        ctr_n = ctr + CW'(1);
                    end
                end
                DATA: begin
                    if (ctr == CTR_LAST) begin
                        ctr_n    = '0;
                        shift_en = 1'b1;
                        if (bit_cnt == BIT_LAST)
                            state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        ctr_n = ctr + CW'(1);
                    end
                end
                PARITY: begin
                    if (ctr == CTR_LAST) begin
                        ctr_n    = '0;
                        state_n  = STOP;
                        par_fail = ^{shreg, line};
                    end else begin
                        ctr_n = ctr + CW'(1);
                    end
                end
                STOP: begin
                    if (ctr == CTR_LAST) begin
                        ctr_n   = '0;
                        state_n = IDLE;
                        if (!line)
                            frame_fail = 1'b1;
                        else if (!bad)
                            push_req = 1'b1;
                    end else begin
                        ctr_n = ctr + CW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    ctr_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt      <= '0;
            shreg        <= '0;
            bad          <= 1'b0;
            push_pending <= 1'b0;
        end else begin
            push_pending <= push_req;
            if (start_frame) begin
                bit_cnt <= '0;
                bad     <= 1'b0;
            end
            if (shift_en) begin
                shreg   <= {line, shreg[DATA_WIDTH-1:1]};
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (par_fail)
                bad <= 1'b1;
        end
    end

    // A pending word is written one edge after the stop sample; a pop in the
    // same cycle frees a slot, so a full FIFO still accepts it.
    assign pop  = rd_en && !empty;
    assign push = push_pending && (!full || pop);
    assign drop = push_pending && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            fifo_count         <= '0;
            character_received <= 1'b0;
        end else begin
            character_received <= push;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= shreg;
    end

    assign data_out = mem[rd_ptr];
    assign empty    = (fifo_count == '0);
    assign full     = (fifo_count == CNT_FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun     <= 1'b0;
            framing_err <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            overrun     <= drop       || (overrun     && !clr_err);
            framing_err <= frame_fail || (framing_err && !clr_err);
            parity_err  <= par_fail   || (parity_err  && !clr_err);
        end
    end

endmodule

// File: tb/tb_serial_receiver_fifo.sv
// Directed bench for serial_receiver_fifo: a default instance and a parity-enabled
// instance, driven with whole serial frames at 16 clk per bit.
module tb_serial_receiver_fifo;

    localparam int OS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, se;
    logic line_a, rd_a, clr_a;
    logic [7:0] dout_a;
    logic cr_a, empty_a, full_a, ovr_a, fe_a, pe_a;
    logic [2:0] cnt_a;
    logic line_p, rd_p, clr_p;
    logic [7:0] dout_p;
    logic cr_p, empty_p, full_p, ovr_p, fe_p, pe_p;
    logic [2:0] cnt_p;

    serial_receiver_fifo dut_a (
        .clk(clk), .rst(rst), .data_in(line_a), .sample_en(se), .rd_en(rd_a),
        .clr_err(clr_a), .data_out(dout_a), .character_received(cr_a),
        .empty(empty_a), .full(full_a), .fifo_count(cnt_a), .overrun(ovr_a),
        .framing_err(fe_a), .parity_err(pe_a)
    );

    serial_receiver_fifo #(.PARITY_EN(1)) dut_p (
        .clk(clk), .rst(rst), .data_in(line_p), .sample_en(se), .rd_en(rd_p),
        .clr_err(clr_p), .data_out(dout_p), .character_received(cr_p),
        .empty(empty_p), .full(full_p), .fifo_count(cnt_p), .overrun(ovr_p),
        .framing_err(fe_p), .parity_err(pe_p)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    int pulses_a = 0, pulses_p = 0, align_err = 0, prev_cnt_a = 0;
    logic rd_prev_a = 1'b0;

    always @(posedge clk) rd_prev_a <= rd_a;

    always @(negedge clk) begin
        if (cr_a) begin
            pulses_a++;
            if (!rd_prev_a && int'(cnt_a) != prev_cnt_a + 1)
                align_err++;
        end
        if (cr_p)
            pulses_p++;
        prev_cnt_a = int'(cnt_a);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame bits: start 0, data LSB first, optional parity, stop. pop_at >= 0
    // raises rd_a for one cycle at that negedge index counted from frame start.
    task automatic send_frame(input logic [15:0] data, input int nbits, input int par,
                              input logic stop, input bit to_p, input int pop_at);
        int total;
        total = nbits + 2 + ((par >= 0) ? 1 : 0);
        for (int b = 0; b < total; b++) begin
            logic v;
            if (b == 0)
                v = 1'b0;
            else if (b <= nbits)
                v = data[b-1];
            else if (par >= 0 && b == nbits + 1)
                v = par[0];
            else
                v = stop;
            if (to_p) line_p = v;
            else      line_a = v;
            for (int c = 0; c < OS; c++) begin
                if (pop_at >= 0)
                    rd_a = ((b * OS + c) == pop_at);
                @(negedge clk);
            end
        end
        if (to_p) line_p = 1'b1;
        else      line_a = 1'b1;
        if (pop_at >= 0)
            rd_a = 1'b0;
        tick(2 * OS);
    endtask

    task automatic read_a(input logic [7:0] exp);
        check("read_data", dout_a, exp);
        rd_a = 1'b1;
        tick(1);
        rd_a = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       clr;
        int         cnt;
        int         npulse;
        logic [7:0] head;
        logic       fe;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int p0;
        vecs[0] = '{data: 8'h3C, stop: 1'b0, clr: 1'b0, cnt: 0, npulse: 0, head: 8'h00, fe: 1'b1};
        vecs[1] = '{data: 8'hA5, stop: 1'b1, clr: 1'b1, cnt: 1, npulse: 1, head: 8'hA5, fe: 1'b0};
        vecs[2] = '{data: 8'h5A, stop: 1'b1, clr: 1'b0, cnt: 2, npulse: 1, head: 8'hA5, fe: 1'b0};
        vecs[3] = '{data: 8'hC3, stop: 1'b0, clr: 1'b0, cnt: 2, npulse: 0, head: 8'hA5, fe: 1'b1};
        vecs[4] = '{data: 8'h81, stop: 1'b1, clr: 1'b1, cnt: 3, npulse: 1, head: 8'hA5, fe: 1'b0};

        rst = 1'b0; se = 1'b1;
        line_a = 1'b1; rd_a = 1'b0; clr_a = 1'b0;
        line_p = 1'b1; rd_p = 1'b0; clr_p = 1'b0;
        tick(4);
        check("rst_empty", empty_a, 1);
        check("rst_full", full_a, 0);
        check("rst_count", cnt_a, 0);
        check("rst_cr", cr_a, 0);
        check("rst_flags", {ovr_a, fe_a, pe_a}, 0);
        rst = 1'b1;
        tick(8);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].clr) begin
                clr_a = 1'b1;
                tick(1);
                clr_a = 1'b0;
                check("clr_fe", fe_a, 0);
            end
            p0 = pulses_a;
            send_frame({8'h00, vecs[i].data}, 8, -1, vecs[i].stop, 1'b0, -1);
            check("vec_count", cnt_a, vecs[i].cnt);
            check("vec_pulses", pulses_a - p0, vecs[i].npulse);
            if (vecs[i].cnt > 0)
                check("vec_head", dout_a, vecs[i].head);
            check("vec_fe", fe_a, vecs[i].fe);
            check("vec_pe", pe_a, 0);
            check("vec_ovr", ovr_a, 0);
        end
        read_a(8'hA5);
        read_a(8'h5A);
        read_a(8'h81);
        check("drain_empty", empty_a, 1);

        // 8-clk low glitch on an idle line
        p0 = pulses_a;
        line_a = 1'b0;
        tick(8);
        line_a = 1'b1;
        tick(40);
        check("glitch_count", cnt_a, 0);
        check("glitch_pulses", pulses_a - p0, 0);
        check("glitch_fe", fe_a, 0);

        // Five frames into a four-deep FIFO
        p0 = pulses_a;
        for (int i = 1; i <= 5; i++) begin
            send_frame(16'(i), 8, -1, 1'b1, 1'b0, -1);
            check("fill_count", cnt_a, (i < 4) ? i : 4);
        end
        check("fill_full", full_a, 1);
        check("fill_ovr", ovr_a, 1);
        check("fill_pulses", pulses_a - p0, 4);
        check("fill_head", dout_a, 8'h01);
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        check("clr_ovr", ovr_a, 0);

        // Push coinciding with a pop while full: stop sample lands 155 clk in
        p0 = pulses_a;
        send_frame(16'h06, 8, -1, 1'b1, 1'b0, 155);
        check("simul_count", cnt_a, 4);
        check("simul_ovr", ovr_a, 0);
        check("simul_pulses", pulses_a - p0, 1);
        read_a(8'h02);
        read_a(8'h03);
        read_a(8'h04);
        read_a(8'h06);
        check("simul_empty", empty_a, 1);
        check("simul_notfull", full_a, 0);

        rd_a = 1'b1;
        tick(2);
        rd_a = 1'b0;
        check("rd_empty_count", cnt_a, 0);
        check("rd_empty_empty", empty_a, 1);
        send_frame(16'h42, 8, -1, 1'b1, 1'b0, -1);
        check("after_underrun_count", cnt_a, 1);
        read_a(8'h42);

        // Reset in the middle of frame 0x55 with a word already stored
        send_frame(16'h77, 8, -1, 1'b1, 1'b0, -1);
        check("pre_rst_count", cnt_a, 1);
        line_a = 1'b0;
        tick(OS);
        for (int b = 0; b < 4; b++) begin
            line_a = (b % 2 == 0);
            tick(OS);
        end
        rst = 1'b0;
        #1;
        check("async_rst_count", cnt_a, 0);
        check("async_rst_empty", empty_a, 1);
        line_a = 1'b1;
        tick(3);
        rst = 1'b1;
        p0 = pulses_a;
        tick(40);
        check("post_rst_count", cnt_a, 0);
        send_frame(16'h99, 8, -1, 1'b1, 1'b0, -1);
        check("post_rst_pulses", pulses_a - p0, 1);
        check("post_rst_count2", cnt_a, 1);
        check("post_rst_head", dout_a, 8'h99);
        check("post_rst_fe", fe_a, 0);

        // Even parity: 0x07 needs parity bit 1
        send_frame(16'h07, 8, 0, 1'b1, 1'b1, -1);
        check("par_bad_count", cnt_p, 0);
        check("par_bad_pe", pe_p, 1);
        check("par_bad_fe", fe_p, 0);
        check("par_bad_pulses", pulses_p, 0);
        send_frame(16'h07, 8, 1, 1'b1, 1'b1, -1);
        check("par_good_count", cnt_p, 1);
        check("par_good_head", dout_p, 8'h07);
        check("par_good_pe", pe_p, 1);
        check("par_good_pulses", pulses_p, 1);

        check("pulse_alignment", align_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_receiver_fifo.md
SERIAL_RECEIVER_FIFO -- requirements
Module: serial_receiver_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning data bits per character (5..16).
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, meaning sample_en strobes per bit period (even, >=4).
REQ-003 The block SHALL have parameter PARITY_EN, default 0, meaning 1 = one even-parity bit follows the data bits.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, meaning received-word buffer entries (power of 2, >=2).
REQ-005 The block SHALL have one clock and an asynchronous active-low reset, with ports as follows:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  1  serial line; idle high; asynchronous to clk.
- sample_en  in  1  oversample strobe, one clk wide.
- rd_en  in  1  pop head word from FIFO.
- clr_err  in  1  clears sticky error flags.
- data_out  out  DATA_WIDTH  FIFO head word (show-ahead).
- character_received  out  1  one-cycle pulse on each word push.
- empty  out  1  FIFO holds 0 words.
- full  out  1  FIFO holds FIFO_DEPTH words.
- fifo_count  out  clog2(FIFO_DEPTH)+1  words held.
- overrun  out  1  sticky: a word was dropped because the FIFO was full.
- framing_err  out  1  sticky: stop bit sampled low.
- parity_err  out  1  sticky: parity mismatch.

Function
REQ-006 data_in SHALL pass through a 2-flop synchronizer (reset value 1) before any use; all line references below mean the synchronized value.
REQ-007 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, with a bit-phase counter that advances only on sample_en.
REQ-008 In IDLE, on sample_en with line = 0, the FSM SHALL enter START with counter = 0.
REQ-009 In START, on the strobe where counter = OVERSAMPLE/2-1, the FSM SHALL enter DATA (counter reset) if line = 0, else return to IDLE (glitch reject); no flags are set on a glitch.
REQ-010 In DATA, PARITY and STOP, the line SHALL be sampled on the strobe where counter = OVERSAMPLE-1, then the counter SHALL reset to 0.
REQ-011 Data bits SHALL be received LSB first into a DATA_WIDTH shift register.
REQ-012 After the DATA_WIDTH-th bit, the FSM SHALL go to PARITY if PARITY_EN = 1, else to STOP.
REQ-013 In PARITY, the sampled bit SHALL make the XOR of data bits and parity bit 0; on mismatch, parity_err SHALL be set and the word marked bad.
REQ-014 In STOP, the sampled bit SHALL be checked:
- stop = 1 and word good: push the word.
- stop = 0: set framing_err and discard the word.
- bad parity: discard the word.
The FSM SHALL return to IDLE in all cases.
REQ-015 On a push, the write SHALL take effect on the clk edge after the stop-bit sample.
REQ-016 character_received SHALL pulse high for exactly one cycle, aligned with fifo_count incrementing.
REQ-017 A push while full (with no simultaneous pop) SHALL drop the new word, set overrun, not pulse character_received, and leave contents unchanged.
REQ-018 rd_en while empty SHALL be ignored with no state change.
REQ-019 Simultaneous push and pop SHALL both succeed, including when full, leaving fifo_count unchanged with no overrun.
REQ-020 data_out SHALL present the head word combinationally from FIFO storage whenever empty = 0; its value is don't-care when empty.
REQ-021 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 Sticky flags SHALL clear on clr_err; a set and a clear in the same cycle SHALL leave the flag set.
REQ-023 sample_en low SHALL freeze the FSM and counter; the FIFO and rd_en remain operational.

Reset
REQ-024 When rst = 0, the block SHALL asynchronously apply the following, regardless of mid-frame state:
- FSM = IDLE, counter = 0, shift register = 0.
- FIFO pointers = 0, fifo_count = 0, empty = 1, full = 0.
- character_received = 0, all sticky flags = 0, synchronizer = 1.
REQ-025 After rst deasserts, a frame SHALL be accepted only from a new falling edge.

Verification
REQ-026 The bench SHALL cover these scenarios (defaults, sample_en tied high, so one bit = 16 clk):
- Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop 1): character_received pulses once, data_out = 0xA5, fifo_count = 1, no flags.
- 8-clk low glitch on idle line: FSM returns to IDLE, fifo_count = 0, no flags.
- Frame 0x3C with stop bit 0: framing_err = 1, fifo_count = 0; clr_err clears it.
- PARITY_EN = 1; send 0x07 with parity 0, then 0x07 with parity 1: first word dropped with parity_err = 1, second pushed.
- Five frames 0x01..0x05 with no reads: first four stored, overrun = 1; reads return 0x01..0x04, then empty = 1.
- rst pulsed low mid-DATA of frame 0x55, then frame 0x99 sent: only 0x99 is received.
